if_fetch_queue: RTL
===================

# if_fetch_queue

Instruction-fetch front end sitting directly upstream of the cache wrapper's IF-stage port. It generates sequential PCs and issues one fetch request at a time to the cache wrapper. Returned instructions are buffered with their PCs in a small FIFO that feeds the ID stage through a valid/ready handshake. Branch/exception redirects squash the FIFO and drive the wrapper's `Flush`.

## Interface
Parameters:
- `RESET_PC`, 32'hBFC0_0000, first fetch address after reset
- `DEPTH`, 4, instruction FIFO entries (power of two, ≥2)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `PC`  out  32  fetch address to cache wrapper
- `Inst_Req_Valid`  out  1  fetch request valid
- `Inst_Req_Ack`  in  1  wrapper request accept (also high whenever `Flush`)
- `instruction`  in  32  returned instruction word
- `pc_req`  in  32  PC associated with `instruction`
- `Inst_Valid`  in  1  returned instruction valid
- `Inst_Ack`  out  1  instruction accepted
- `Flush`  out  1  squash in-flight fetch
- `redirect_valid`  in  1  redirect from ID/EX/exception logic
- `redirect_pc`  in  32  redirect target
- `id_valid`  out  1  FIFO head valid
- `id_ready`  in  1  ID stage accepts head
- `id_inst`  out  32  head instruction
- `id_pc`  out  32  head PC
- `id_adel`  out  1  head carries a fetch address-error mark

## Operation
- State: `fetch_pc`, `outstanding` flag, `halted` flag, FIFO (`inst`,`pc`,`adel`) with read/write pointers and count.
- Credit: request allowed only if `count + outstanding < DEPTH`; a response therefore always has a free slot.
- `Inst_Req_Valid = ~rst & ~outstanding & ~halted & ~redirect_valid & credit`; `PC = fetch_pc`.
- Accept = `Inst_Req_Valid & Inst_Req_Ack & ~Flush`. On accept: `outstanding<=1`, `fetch_pc<=fetch_pc+4` (mod 2^32, 32'hFFFF_FFFC wraps to 0).
- `Inst_Ack = outstanding`. Response = `Inst_Valid & outstanding`: enqueue {`instruction`, `pc_req`, 0}, `outstanding<=0`. `Inst_Valid` while not outstanding is ignored.
- Dequeue on `id_valid & id_ready`. Simultaneous enqueue and dequeue keep count unchanged.
- Redirect (`redirect_valid`=1): `Flush=1` the same cycle (combinational); next edge: FIFO emptied, `outstanding<=0`, `halted<=0`, `fetch_pc<=redirect_pc`. Redirect wins over any same-cycle accept, response, or dequeue; all three are discarded.
- Reset: `fetch_pc=RESET_PC`, FIFO empty, `outstanding=0`, `halted=0`. Outputs during/after reset: `Inst_Req_Valid=0`, `Inst_Ack=0`, `Flush=redirect_valid`, `id_valid=0`, `id_inst/id_pc=0`, `id_adel=0`. Reset mid-transfer drops all state; the first request after reset is `RESET_PC`.

## Timing
- Request accepted at cycle T → `PC` shows next address at T+1; no new request before the response.
- Response at cycle R → `id_valid=1` at R+1 (no bypass).
- Redirect at T → `Inst_Req_Valid` may assert at T+1 with `PC=redirect_pc`.
- Steady-state throughput is bounded by cache latency, one instruction per response.
- FIFO full (`count=DEPTH`) or `count=DEPTH-1` with an outstanding request → no request issued.

## Configuration
- `IF_ADEL_CHECK_EN` defined: if `fetch_pc[1:0]!=0` and a request would otherwise be allowed, no bus request is issued. An entry {`inst`=0, `pc`=`fetch_pc`, `adel`=1} is enqueued and `halted<=1` until a redirect.
- Undefined: `PC={fetch_pc[31:2],2'b00}`, no check, `id_adel` is constantly 0.

## Test plan
- Reset release, wrapper acks after 1 cycle and returns data after 2 → `PC` sequence BFC00000, BFC00004, BFC00008; `id_pc` in the same order and `id_valid` 1 cycle after each `Inst_Valid`.
- `id_ready=0`, DEPTH=4 → exactly 4 instructions buffered, `Inst_Req_Valid` stays 0. Then `id_ready=1` for one cycle → one new request issued.
- Redirect to 0x8000_0100 while a request is outstanding → `Flush=1` that cycle, `id_valid=0` next cycle, next `PC`=0x8000_0100, and the stale response is never enqueued.
- `redirect_valid`, `Inst_Valid`, and `id_ready` all asserted in the same cycle → FIFO empty afterwards, count=0, `fetch_pc=redirect_pc`.
- With `IF_ADEL_CHECK_EN`, redirect to 0x8000_0102 → no request; head has `id_adel=1`, `id_pc`=0x8000_0102, `id_inst`=0; fetch stays halted until a redirect to 0x8000_0200.
- Assert `rst` for 1 cycle with 2 entries queued and 1 outstanding → `id_valid=0` and the next `PC`=BFC00000; a late `Inst_Valid` is ignored.

Source files
------------

// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: fetch-side bundle connecting the fetch queue to the cache
// wrapper IF port, the redirect source and the ID stage.
// master = fetch queue side, slave = environment (wrapper, redirect logic, ID).
interface if_fetch_queue_if;
  // Cache wrapper request/response
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ack;
  logic [31:0] instruction;
  logic [31:0] pc_req;
  logic        Inst_Valid;
  logic        Inst_Ack;
  logic        Flush;
  // Redirect from ID/EX/exception logic
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // ID stage handshake
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_adel;

  modport master (
    output PC, Inst_Req_Valid, Inst_Ack, Flush, id_valid, id_inst, id_pc, id_adel,
    input  Inst_Req_Ack, instruction, pc_req, Inst_Valid, redirect_valid, redirect_pc,
           id_ready
  );

  modport slave (
    input  PC, Inst_Req_Valid, Inst_Ack, Flush, id_valid, id_inst, id_pc, id_adel,
    output Inst_Req_Ack, instruction, pc_req, Inst_Valid, redirect_valid, redirect_pc,
           id_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: sequential-PC fetch front end. Issues one fetch at a time to the
// cache wrapper, buffers returned {inst, pc, adel} in a DEPTH-entry FIFO for ID,
// and squashes everything on a redirect.
// Optional feature macro: IF_ADEL_CHECK_EN (misaligned fetch_pc produces an
// address-error entry instead of a bus request and halts fetch until redirect).
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned DEPTH    = 4
) (
  input logic              clk,
  input logic              rst,
  if_fetch_queue_if.master bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adel;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             outstanding_q, outstanding_d;
  logic             halted_q, halted_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic   credit_c, allowed_c, adel_c, req_valid_c, accept_c;
  logic   resp_c, head_valid_c, deq_c, push_c;
  entry_t push_entry_c, head_c;

  // Request gating (credit keeps a free slot for every outstanding response) and FIFO events.
  always_comb begin
    credit_c  = (32'(count_q) + 32'(outstanding_q)) < DEPTH;
    allowed_c = ~rst & ~outstanding_q & ~halted_q & ~bus.redirect_valid & credit_c;
`ifdef IF_ADEL_CHECK_EN
    adel_c    = allowed_c & (fetch_pc_q[1:0] != 2'b00);
`else
    adel_c    = 1'b0;
`endif
    req_valid_c  = allowed_c & ~adel_c;
    accept_c     = req_valid_c & bus.Inst_Req_Ack & ~bus.redirect_valid;
    resp_c       = ~rst & outstanding_q & bus.Inst_Valid;
    head_valid_c = ~rst & (count_q != '0);
    deq_c        = head_valid_c & bus.id_ready;
    push_c       = resp_c | adel_c;
    if (adel_c) begin
      push_entry_c = '{inst: 32'h0, pc: fetch_pc_q, adel: 1'b1};
    end else begin
      push_entry_c = '{inst: bus.instruction, pc: bus.pc_req, adel: 1'b0};
    end
    head_c = head_valid_c ? mem_q[rd_ptr_q] : '0;
  end

  // Next-state: a redirect discards any same-cycle accept, response or dequeue.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    halted_d      = halted_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (bus.redirect_valid) begin
      fetch_pc_d    = bus.redirect_pc;
      outstanding_d = 1'b0;
      halted_d      = 1'b0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
    end else begin
      if (accept_c) begin
        outstanding_d = 1'b1;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end
      if (resp_c) begin
        outstanding_d = 1'b0;
      end
      if (adel_c) begin
        halted_d = 1'b1;
      end
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (deq_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_c, deq_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= 1'b0;
      halted_q      <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      halted_q      <= halted_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Entry storage: contents are only visible when qualified by count.
  always_ff @(posedge clk) begin
    if (~rst & ~bus.redirect_valid & push_c) begin
      mem_q[wr_ptr_q] <= push_entry_c;
    end
  end

  assign bus.Inst_Req_Valid = req_valid_c;
`ifdef IF_ADEL_CHECK_EN
  assign bus.PC             = fetch_pc_q;
`else
  assign bus.PC             = {fetch_pc_q[31:2], 2'b00};
`endif
  assign bus.Inst_Ack       = ~rst & outstanding_q;
  assign bus.Flush          = bus.redirect_valid;
  assign bus.id_valid       = head_valid_c;
  assign bus.id_inst        = head_c.inst;
  assign bus.id_pc          = head_c.pc;
  assign bus.id_adel        = head_c.adel;

endmodule
